// File: rtl/registros_vga.sv
// rtl/registros_vga.sv - PicoBlaze-written VGA field registers with vsync-coherent shadow copy
// Writes are validated (one-hot, BCD) and published to the renderer only on a vsync falling edge.
module registros_vga #(
    parameter int              N_REG    = 9,
    parameter int              ANCHO    = 8,
    parameter logic [N_REG-1:0] MASK_BCD = 'h0FF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REG-1:0]         enable,
    input  logic                     write_strobe,
    input  logic [ANCHO-1:0]         dato_in,
    input  logic                     vsync,
    input  logic [3:0]               rd_sel,
    output logic [N_REG*ANCHO-1:0]   disp_data,
    output logic [ANCHO-1:0]         dato_out,
    output logic                     pendiente,
    output logic                     actualizado,
    output logic                     err_bcd
);

    typedef enum logic {LIMPIO, PENDIENTE} estado_t;

    estado_t          state_q, state_d;
    logic             ws_q;
    logic [ANCHO-1:0] dato_q;
    logic [ANCHO-1:0] work_q   [N_REG];
    logic [ANCHO-1:0] shadow_q [N_REG];
    logic             vs_s1_q, vs_s2_q, vs_prev_q;
    logic             actualizado_q, err_q;
    logic [ANCHO-1:0] dato_out_q, dato_out_d;

    logic vs_evt, hit, onehot, checked, bcd_ok, acc, rej, publish;

    assign vs_evt = vs_prev_q & ~vs_s2_q;

    // enable is registered upstream, so it lines up with the one-cycle-delayed strobe/data
    always_comb begin
        hit     = ws_q && (enable != '0);
        onehot  = (enable & (enable - N_REG'(1))) == '0;
        checked = |(enable & MASK_BCD);
        bcd_ok  = 1'b1;
        for (int n = 0; n < ANCHO / 4; n++) begin
            if (dato_q[4*n +: 4] > 4'd9) bcd_ok = 1'b0;
        end
        acc     = hit && onehot && (!checked || bcd_ok);
        rej     = hit && !acc;
        publish = (state_q == PENDIENTE) && vs_evt;
    end

    // A write landing in the publish cycle keeps the set pending for the next frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            LIMPIO:    if (acc) state_d = PENDIENTE;
            PENDIENTE: if (vs_evt && !acc) state_d = LIMPIO;
            default:   state_d = LIMPIO;
        endcase
    end

    always_comb begin
        dato_out_d = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (rd_sel == 4'(i)) dato_out_d = work_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_q          <= 1'b0;
            dato_q        <= '0;
            vs_s1_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            vs_prev_q     <= 1'b1;
            state_q       <= LIMPIO;
            actualizado_q <= 1'b0;
            err_q         <= 1'b0;
            dato_out_q    <= '0;
            for (int i = 0; i < N_REG; i++) begin
                work_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            ws_q          <= write_strobe;
            dato_q        <= dato_in;
            vs_s1_q       <= vsync;
            vs_s2_q       <= vs_s1_q;
            vs_prev_q     <= vs_s2_q;
            state_q       <= state_d;
            actualizado_q <= publish;
            dato_out_q    <= dato_out_d;
            if (acc)      err_q <= 1'b0;
            else if (rej) err_q <= 1'b1;
            for (int i = 0; i < N_REG; i++) begin
                if (acc && enable[i]) work_q[i]   <= dato_q;
                if (publish)          shadow_q[i] <= work_q[i];
            end
        end
    end

    for (genvar g = 0; g < N_REG; g++) begin : g_disp
        assign disp_data[g*ANCHO +: ANCHO] = shadow_q[g];
    end

    assign dato_out    = dato_out_q;
    assign pendiente   = (state_q == PENDIENTE);
    assign actualizado = actualizado_q;
    assign err_bcd     = err_q;

endmodule
